// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default widths for the SAP-1.5 program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, VERIFY, RUN, DONE, TIMEOUT} loader_state_t;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CYC_W_DEF = 8;
endpackage

// File: rtl/loader_watchdog.sv
// loader_watchdog: saturating run-cycle counter with clear and budget expiry (budget 0 never expires).
module loader_watchdog #(
  parameter int CYC_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CYC_W-1:0] budget_i,
  output logic [CYC_W-1:0] count_o,
  output logic             expire_o
);
  logic [CYC_W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : (en_i && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
  assign expire_o = (budget_i != '0) && (count_q == budget_i - 1'b1);
endmodule

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: SAP-1.5 loader that clears RAM, streams a program in, then runs the CPU to HLT or budget.
// Define LOADER_READBACK_EN to add a post-load readback check (VERIFY) with ram_rdata_i/verify_err_o.
module prog_loader_ctrl
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [CYC_W-1:0]  max_cycles_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              cpu_reset_o,
  input  logic              cpu_halt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CYC_W-1:0]  cycle_count_o
`ifdef LOADER_READBACK_EN
  ,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              verify_err_o
`endif
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  loader_state_t state_q;
  logic [ADDR_W-1:0] base_q, ptr_q;
  logic [ADDR_W:0] len_q, rem_q;
  logic [CYC_W-1:0] max_q;
  logic start_ok, xfer, expire;
  assign start_ok = start_i && (state_q == IDLE || state_q == DONE || state_q == TIMEOUT);
  assign xfer = state_q == LOAD && in_valid_i;
`ifdef LOADER_READBACK_EN
  logic [DATA_W-1:0] shadow_q, acc_q;
  logic verr_q;
  assign verify_err_o = verr_q;
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      base_q <= '0;
      ptr_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      max_q <= '0;
`ifdef LOADER_READBACK_EN
      shadow_q <= '0;
      acc_q <= '0;
      verr_q <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        state_q <= CLEAR;
        base_q <= base_addr_i;
        len_q <= len_i > DEPTH ? DEPTH : len_i;
        max_q <= max_cycles_i;
        ptr_q <= '0;
`ifdef LOADER_READBACK_EN
        shadow_q <= '0;
        acc_q <= '0;
        verr_q <= 1'b0;
`endif
      end
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (&ptr_q) begin
            ptr_q <= base_q;
            rem_q <= len_q;
            state_q <= len_q == '0 ? RUN : LOAD;
          end
        end
        LOAD: if (in_valid_i) begin
          ptr_q <= ptr_q + 1'b1;
          rem_q <= rem_q - 1'b1;
`ifdef LOADER_READBACK_EN
          shadow_q <= shadow_q ^ in_data_i;
`endif
          if (rem_q == (ADDR_W + 1)'(1)) begin
`ifdef LOADER_READBACK_EN
            state_q <= VERIFY;
            ptr_q <= base_q;
            rem_q <= '0;
`else
            state_q <= RUN;
`endif
          end
        end
`ifdef LOADER_READBACK_EN
        // rem_q counts issued reads; data for the previous address arrives one cycle later
        VERIFY: begin
          ptr_q <= ptr_q + 1'b1;
          rem_q <= rem_q + 1'b1;
          if (rem_q != '0) acc_q <= acc_q ^ ram_rdata_i;
          if (rem_q == len_q) begin
            verr_q <= (acc_q ^ ram_rdata_i) != shadow_q;
            state_q <= (acc_q ^ ram_rdata_i) != shadow_q ? TIMEOUT : RUN;
          end
        end
`endif
        RUN: begin
          if (cpu_halt_i) state_q <= DONE;
          else if (expire) state_q <= TIMEOUT;
        end
        default: ;
      endcase
    end
  end
  loader_watchdog #(.CYC_W(CYC_W)) u_wd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (state_q == RUN),
    .clr_i    (start_ok),
    .budget_i (max_q),
    .count_o  (cycle_count_o),
    .expire_o (expire)
  );
  assign in_ready_o = state_q == LOAD;
  assign ram_we_o = !reset_i && (state_q == CLEAR || xfer);
  assign ram_addr_o = (state_q == CLEAR || state_q == LOAD || state_q == VERIFY) ? ptr_q : '0;
  assign ram_wdata_o = xfer ? in_data_i : state_q == CLEAR ? CLR_VAL : '0;
  assign cpu_reset_o = !(state_q == RUN || state_q == DONE);
  assign busy_o = state_q == CLEAR || state_q == LOAD || state_q == VERIFY || state_q == RUN;
  assign done_o = state_q == DONE;
  assign timeout_o = state_q == TIMEOUT;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// tb_prog_loader_ctrl: table-driven and randomized bench with a 16x8 RAM model and a halting CPU stub.
module tb_prog_loader_ctrl;
  localparam int AW = 4, DW = 8, CW = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, cpu_halt;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] len = '0;
  logic [CW-1:0] max_cycles = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, ram_we, cpu_reset, busy, done, timeout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [CW-1:0] cycle_count;
`ifdef LOADER_READBACK_EN
  logic [DW-1:0] ram_rdata = '0;
  logic verify_err;
  logic corrupt = 1'b0;
`endif
  int errors = 0, checks = 0;
  int halt_n = 0;
  int rel = 0;
  logic preload = 1'b0;
  logic [DW-1:0] ram [16];
  logic [AW-1:0] wr_a [$];
  logic [DW-1:0] wr_d [$];

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    logic [7:0] maxc;
    int halt;
    int mode;
    logic [7:0] b0, b1, b2, b3;
    bit exp_done;
    int exp_cnt;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  prog_loader_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CYC_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .base_addr_i(base_addr), .len_i(len),
    .max_cycles_i(max_cycles), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .cpu_reset_o(cpu_reset),
    .cpu_halt_i(cpu_halt), .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .cycle_count_o(cycle_count)
`ifdef LOADER_READBACK_EN
    , .ram_rdata_i(ram_rdata), .verify_err_o(verify_err)
`endif
  );

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 16; i++) ram[i] <= 8'hAA;
    else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
      wr_a.push_back(ram_addr);
      wr_d.push_back(ram_wdata);
    end
`ifdef LOADER_READBACK_EN
    ram_rdata <= ram[ram_addr] ^ ((corrupt && ram_addr == 4'd1) ? 8'h5A : 8'h00);
`endif
    rel <= cpu_reset ? 0 : rel + 1;
  end
  assign cpu_halt = halt_n != 0 && !cpu_reset && rel >= halt_n - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit vld(input int mode, input int c);
    return mode == 0 || (c % 3) == 0;
  endfunction

  // Cycle (counted from the cycle after the start edge) in which the CPU is first released.
  function automatic int exp_run_at(input int l, input int mode);
    int c = 16, n = 0;
    if (l == 0) return 16;
    while (n < l) begin
      if (vld(mode, c)) n++;
      c++;
    end
`ifdef LOADER_READBACK_EN
    c += l + 1;
`endif
    return c;
  endfunction

  task automatic do_start(input logic [3:0] b, input logic [4:0] l, input logic [7:0] m, input int hn);
    halt_n = hn;
    base_addr = b;
    len = l;
    max_cycles = m;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive(input int lc, input int mode, input logic [7:0] d [17], output int run_at, output int idx);
    int cyc = 0;
    bit hs;
    run_at = -1;
    idx = 0;
    while (!(done || timeout) && cyc < 700) begin
      in_valid = (idx <= lc) && vld(mode, cyc);
      in_data = d[idx];
      #1;
      hs = in_valid && in_ready;
      if (!cpu_reset && run_at < 0) run_at = cyc;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("end_reached", 32'(done || timeout), 32'd1);
  endtask

  task automatic run_txn(input string nm, input logic [3:0] b, input logic [4:0] l, input logic [7:0] m,
                         input int hn, input int mode, input logic [7:0] d [17], input bit exp_done, input int exp_cnt);
    int lc, run_at, idx, wb, bad_clr, bad_ram;
    logic [7:0] exp_ram [16];
    lc = l > 5'd16 ? 16 : int'(l);
    preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    wb = wr_a.size();
    do_start(b, l, m, hn);
    chk({nm, ".start"}, {21'd0, done, timeout, busy, cycle_count}, {21'd0, 3'b001, 8'd0});
`ifdef LOADER_READBACK_EN
    chk({nm, ".verr_clr"}, 32'(verify_err), 32'd0);
`endif
    drive(lc, mode, d, run_at, idx);
    chk({nm, ".run_at"}, 32'(run_at), 32'(exp_run_at(lc, mode)));
    chk({nm, ".done"}, 32'(done), 32'(exp_done));
    chk({nm, ".timeout"}, 32'(timeout), 32'(!exp_done));
    chk({nm, ".count"}, 32'(cycle_count), 32'(exp_cnt));
    chk({nm, ".cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    chk({nm, ".busy_rdy"}, {30'd0, busy, in_ready}, 32'd0);
    chk({nm, ".accepted"}, 32'(idx), 32'(lc));
    chk({nm, ".writes"}, 32'(wr_a.size() - wb), 32'(16 + lc));
    bad_clr = 0;
    for (int i = 0; i < 16 && wb + i < wr_a.size(); i++)
      if (int'(wr_a[wb + i]) != i || wr_d[wb + i] != 8'h00) bad_clr++;
    chk({nm, ".clear_seq"}, 32'(bad_clr), 32'd0);
    for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
    for (int i = 0; i < lc; i++) exp_ram[(int'(b) + i) % 16] = d[i];
    bad_ram = 0;
    for (int i = 0; i < 16; i++)
      if (ram[i] !== exp_ram[i]) begin
        bad_ram++;
        $display("  %s ram[%0d]=%h want %h", nm, i, ram[i], exp_ram[i]);
      end
    chk({nm, ".ram"}, 32'(bad_ram), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] d [17];
    int run_at, idx, wb, nw, cyc, hn, m, l, b, mode, ec;
    bit hs, ed;
    tbl[0] = '{4'h0, 5'd2,  8'd50, 5, 0, 8'h88, 8'hFF, 8'h00, 8'h00, 1'b1, 5};
    tbl[1] = '{4'h0, 5'd0,  8'd0,  3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3};
    tbl[2] = '{4'hE, 5'd4,  8'd50, 2, 0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 2};
    tbl[3] = '{4'h5, 5'd1,  8'd10, 0, 0, 8'h5C, 8'h00, 8'h00, 8'h00, 1'b0, 10};
    tbl[4] = '{4'h7, 5'd17, 8'd1,  1, 0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1};
    tbl[5] = '{4'h9, 5'd3,  8'd1,  2, 1, 8'hC3, 8'h3C, 8'h7E, 8'h00, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {23'd0, in_ready, ram_we, ram_addr, cpu_reset, busy, done, timeout},
        {23'd0, 2'b00, 4'h0, 4'b1000});
    chk("reset.wdata", 32'(ram_wdata), 32'd0);
    chk("reset.count", 32'(cycle_count), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle.outs", {25'd0, in_ready, ram_we, cpu_reset, busy, done, timeout, 1'b0}, {25'd0, 7'b0010000});

    foreach (tbl[k]) begin
      d[0] = tbl[k].b0; d[1] = tbl[k].b1; d[2] = tbl[k].b2; d[3] = tbl[k].b3;
      for (int i = 4; i < 17; i++) d[i] = 8'(i * 37 + k);
      run_txn($sformatf("vec%0d", k), tbl[k].base, tbl[k].len, tbl[k].maxc, tbl[k].halt, tbl[k].mode,
              d, tbl[k].exp_done, tbl[k].exp_cnt);
    end

    // Never halts, no budget: counter saturates and start is ignored while running.
    do_start(4'h0, 5'd0, 8'd0, 0);
    repeat (16 + 260) @(posedge clk);
    #1;
    chk("sat.count", 32'(cycle_count), 32'd255);
    chk("sat.state", {28'd0, busy, cpu_reset, done, timeout}, {28'd0, 4'b1000});
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("sat.start_ignored", {23'd0, busy, cycle_count}, {23'd0, 1'b1, 8'd255});
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("sat.reset", {22'd0, cpu_reset, busy, done, timeout, ram_we, in_ready, cycle_count[3:0]},
        {22'd0, 6'b100000, 4'h0});

    // Gapped stream with reset asserted mid-LOAD.
    for (int i = 0; i < 17; i++) d[i] = 8'(8'hA1 + i);
    wb = wr_a.size();
    do_start(4'h3, 5'd8, 8'd0, 4);
    cyc = 0; idx = 0;
    while (idx < 2 && cyc < 100) begin
      in_valid = vld(1, cyc);
      in_data = d[idx];
      #1;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    chk("mid.accepted", 32'(idx), 32'd2);
    in_valid = 1'b1;
    in_data = 8'hEE;
    reset = 1'b1;
    nw = wr_a.size();
    chk("mid.writes_before", 32'(nw - wb), 32'd18);
    #1;
    chk("mid.we_in_reset", 32'(ram_we), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid.no_writes", 32'(wr_a.size() - nw), 32'd0);
    chk("mid.idle", {27'd0, cpu_reset, busy, in_ready, done, timeout}, {27'd0, 5'b10000});
    chk("mid.ram", {16'd0, ram[3], ram[4]}, {16'd0, d[0], d[1]});
    in_valid = 1'b0;

`ifdef LOADER_READBACK_EN
    corrupt = 1'b1;
    do_start(4'h0, 5'd3, 8'd50, 1);
    drive(3, 0, d, run_at, idx);
    chk("verify.err", {29'd0, verify_err, timeout, done}, {29'd0, 3'b110});
    chk("verify.never_released", 32'(run_at), 32'hFFFF_FFFF);
    chk("verify.cpu_reset", 32'(cpu_reset), 32'd1);
    corrupt = 1'b0;
`endif

    for (int t = 0; t < 8; t++) begin
      b = $urandom_range(0, 15);
      l = $urandom_range(0, 17);
      m = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      hn = $urandom_range(0, 40);
      if (hn == 0 && m == 0) hn = 7;
      mode = $urandom_range(0, 1);
      for (int i = 0; i < 17; i++) d[i] = 8'($urandom);
      ed = hn != 0 && (m == 0 || hn <= m);
      ec = ed ? hn : m;
      run_txn($sformatf("rnd%0d", t), 4'(b), 5'(l), 8'(m), hn, mode, d, ed, ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
